// File: rtl/sram_loader_pkg.sv
`default_nettype none
// ============================================================================
// sram_loader_pkg : shared state encoding and default sizing for the loader
// Rev 1.0
// ============================================================================
package sram_loader_pkg;

    localparam int DEF_NUM_BANKS = 6;
    localparam int DEF_LANE_W    = 48;
    localparam int DEF_LANES     = 5;
    localparam int DEF_ADDR_W    = 8;
    localparam int DEF_BANK_W    = 3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ASSEMBLE = 2'd1,
        ST_COMMIT   = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sram_bank_2r1w.sv
`default_nettype none
// ============================================================================
// sram_bank_2r1w : one line memory, single write port, two registered
//                  write-first read ports. Rev 1.0
// ============================================================================
module sram_bank_2r1w #(
    parameter int ADDR_W = 8,
    parameter int LINE_W = 240
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [LINE_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [LINE_W-1:0] rdata0,
    output logic [LINE_W-1:0] rdata1
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [LINE_W-1:0] mem [DEPTH];

    // Array is deliberately left out of reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata0 <= '0;
            rdata1 <= '0;
        end else begin
            rdata0 <= (we && (raddr0 == waddr)) ? wdata : mem[raddr0];
            rdata1 <= (we && (raddr1 == waddr)) ? wdata : mem[raddr1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_bank_loader.sv
`default_nettype none
// ============================================================================
// sram_bank_loader : assembles narrow host beats into lines and commits them
//                    into NUM_BANKS dual-read line memories. Rev 1.0
// ============================================================================
module sram_bank_loader
    import sram_loader_pkg::*;
#(
    parameter int NUM_BANKS = DEF_NUM_BANKS,
    parameter int LANE_W    = DEF_LANE_W,
    parameter int LANES     = DEF_LANES,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int BANK_W    = DEF_BANK_W
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                load_valid,
    output logic                                load_ready,
    input  logic                                load_start,
    input  logic [BANK_W-1:0]                   load_bank,
    input  logic [ADDR_W-1:0]                   load_addr,
    input  logic [LANE_W-1:0]                   load_data,
    input  logic [NUM_BANKS*2*ADDR_W-1:0]       rd_addr,
    output logic [NUM_BANKS*2*LANE_W*LANES-1:0] rd_data,
    output logic                                core_hold,
    output logic [15:0]                         lines_written,
    output logic                                bank_err
);

    localparam int LINE_W = LANE_W * LANES;
    localparam int CNT_W  = $clog2(LANES + 1);

    state_t              state;
    logic [CNT_W-1:0]    lane_cnt;
    logic [LINE_W-1:0]   line_buf;
    logic [BANK_W-1:0]   line_bank;
    logic [ADDR_W-1:0]   line_addr;
    logic [ADDR_W-1:0]   next_addr;
    logic                accept;
    logic                bank_ok;
    logic                commit_en;

    assign load_ready = (state != ST_COMMIT);
    assign core_hold  = (state != ST_IDLE) | load_valid;
    assign accept     = load_valid & load_ready;
    assign bank_ok    = ({1'b0, line_bank} < (BANK_W + 1)'(NUM_BANKS));
    assign commit_en  = (state == ST_COMMIT) & bank_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            lane_cnt      <= '0;
            line_buf      <= '0;
            line_bank     <= '0;
            line_addr     <= '0;
            next_addr     <= '0;
            lines_written <= '0;
            bank_err      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        line_buf[LANE_W-1:0] <= load_data;
                        line_bank            <= load_bank;
                        line_addr            <= load_start ? load_addr : next_addr;
                        lane_cnt             <= CNT_W'(1);
                        state                <= (LANES == 1) ? ST_COMMIT : ST_ASSEMBLE;
                    end
                end
                ST_ASSEMBLE: begin
                    if (accept) begin
                        line_buf[lane_cnt*LANE_W +: LANE_W] <= load_data;
                        lane_cnt <= lane_cnt + 1'b1;
                        if (lane_cnt == CNT_W'(LANES - 1)) begin
                            state <= ST_COMMIT;
                        end
                    end
                end
                ST_COMMIT: begin
                    // The address advances even for a rejected bank so the host's
                    // implicit address sequence stays aligned.
                    next_addr <= line_addr + 1'b1;
                    lane_cnt  <= '0;
                    state     <= ST_IDLE;
                    if (bank_ok) begin
                        if (lines_written != 16'hFFFF) begin
                            lines_written <= lines_written + 16'd1;
                        end
                    end else begin
                        bank_err <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic we;
        assign we = commit_en & (line_bank == BANK_W'(b));

        sram_bank_2r1w #(
            .ADDR_W (ADDR_W),
            .LINE_W (LINE_W)
        ) u_bank (
            .clk    (clk),
            .rst_n  (rst_n),
            .we     (we),
            .waddr  (line_addr),
            .wdata  (line_buf),
            .raddr0 (rd_addr[(2*b)*ADDR_W +: ADDR_W]),
            .raddr1 (rd_addr[(2*b+1)*ADDR_W +: ADDR_W]),
            .rdata0 (rd_data[(2*b)*LINE_W +: LINE_W]),
            .rdata1 (rd_data[(2*b+1)*LINE_W +: LINE_W])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_bank_loader.sv
`default_nettype none
// ============================================================================
// tb_sram_bank_loader : directed plus randomized line loads against a
//                       line-level reference model. Rev 1.0
// ============================================================================
module tb_sram_bank_loader;

    localparam int NB    = 6;
    localparam int LW    = 48;
    localparam int LN    = 5;
    localparam int AW    = 8;
    localparam int BW    = 3;
    localparam int LINEW = LW * LN;
    localparam int DEPTH = 256;
    localparam int NP    = NB * 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 load_valid = 1'b0;
    logic                 load_ready;
    logic                 load_start = 1'b0;
    logic [BW-1:0]        load_bank = '0;
    logic [AW-1:0]        load_addr = '0;
    logic [LW-1:0]        load_data = '0;
    logic [NP*AW-1:0]     rd_addr = '0;
    logic [NP*LINEW-1:0]  rd_data;
    logic                 core_hold;
    logic [15:0]          lines_written;
    logic                 bank_err;

    sram_bank_loader #(
        .NUM_BANKS (NB),
        .LANE_W    (LW),
        .LANES     (LN),
        .ADDR_W    (AW),
        .BANK_W    (BW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_valid    (load_valid),
        .load_ready    (load_ready),
        .load_start    (load_start),
        .load_bank     (load_bank),
        .load_addr     (load_addr),
        .load_data     (load_data),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .core_hold     (core_hold),
        .lines_written (lines_written),
        .bank_err      (bank_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit rnd_rd = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [LINEW-1:0] act, input logic [LINEW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: line-level view of the loader
    logic [LINEW-1:0] mem [NB][DEPTH];
    bit               wr  [NB][DEPTH];
    logic [LINEW-1:0] m_line;
    logic [LINEW-1:0] rd_exp [NP];
    bit               rd_known [NP];
    bit               m_commit;
    int               m_beats, m_bank, m_addr, m_next, m_lines;
    bit               m_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_commit = 0; m_beats = 0; m_next = 0; m_lines = 0; m_err = 0;
            for (int i = 0; i < NP; i++) begin
                rd_exp[i] = '0;
                rd_known[i] = 1;
            end
        end else begin
            for (int b = 0; b < NB; b++) begin
                for (int p = 0; p < 2; p++) begin
                    int a;
                    a = int'(rd_addr[(2*b+p)*AW +: AW]);
                    if (m_commit && m_bank == b && a == m_addr) begin
                        rd_exp[2*b+p] = m_line;
                        rd_known[2*b+p] = 1;
                    end else begin
                        rd_exp[2*b+p] = mem[b][a];
                        rd_known[2*b+p] = wr[b][a];
                    end
                end
            end
            if (m_commit) begin
                if (m_bank < NB) begin
                    mem[m_bank][m_addr] = m_line;
                    wr[m_bank][m_addr] = 1;
                    if (m_lines != 65535) m_lines++;
                end else begin
                    m_err = 1;
                end
                m_next = (m_addr + 1) % DEPTH;
                m_commit = 0;
                m_beats = 0;
            end else if (load_valid) begin
                if (m_beats == 0) begin
                    m_bank = int'(load_bank);
                    m_addr = load_start ? int'(load_addr) : m_next;
                end
                m_line[m_beats*LW +: LW] = load_data;
                m_beats++;
                if (m_beats == LN) m_commit = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("load_ready", LINEW'(load_ready), LINEW'(!m_commit));
            chk("core_hold", LINEW'(core_hold), LINEW'(m_commit || m_beats != 0 || load_valid));
            chk("lines_written", LINEW'(lines_written), LINEW'(m_lines));
            chk("bank_err", LINEW'(bank_err), LINEW'(m_err));
            for (int i = 0; i < NP; i++) begin
                if (rd_known[i]) chk($sformatf("rd_data[%0d]", i), rd_data[i*LINEW +: LINEW], rd_exp[i]);
            end
        end
    end

    function automatic logic [AW-1:0] pick_addr();
        logic [AW-1:0] a;
        a = ($urandom % 2 == 0) ? AW'($urandom_range(0, 9)) : AW'(8'hF8 + $urandom_range(0, 7));
        return a;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd_rd) begin
            for (int i = 0; i < NP; i++) rd_addr[i*AW +: AW] = pick_addr();
        end
    endtask

    task automatic send_line(input int bank, input bit start, input int addr,
                             input logic [LINEW-1:0] line, input int nbeats,
                             input int gap_at, input int gap_len, input bit junk);
        for (int k = 0; k < nbeats; k++) begin
            int guard;
            if (k == gap_at) begin
                load_valid = 1'b0;
                repeat (gap_len) step();
            end
            load_valid = 1'b1;
            load_data  = line[k*LW +: LW];
            load_start = (k == 0) ? start : (junk ? 1'($urandom) : 1'b0);
            load_bank  = (k == 0 || !junk) ? BW'(bank) : BW'($urandom);
            load_addr  = (k == 0 || !junk) ? AW'(addr) : AW'($urandom);
            guard = 0;
            while (!load_ready && guard < 20) begin
                step();
                guard++;
            end
            if (guard >= 20) begin
                errors++;
                $display("FAIL load_ready_timeout actual=0 required=1");
            end
            step();
        end
        load_valid = 1'b0;
        load_start = 1'b0;
    endtask

    function automatic logic [LINEW-1:0] fill(input logic [LW-1:0] v);
        return {LN{v}};
    endfunction

    logic [LINEW-1:0] L1, L2a, L2b, L2c, L3, LX, LZ, LW0, LG, LR;
    int cstart;

    initial begin
        foreach (wr[b, a]) wr[b][a] = 0;
        L1  = {48'h5, 48'h4, 48'h3, 48'h2, 48'h1};
        L2a = fill(48'h0000_0000_00A1);
        L2b = fill(48'h0000_0000_00A2);
        L2c = fill(48'h0000_0000_00A3);
        L3  = {48'h33, 48'h34, 48'h35, 48'h36, 48'h37};
        LX  = fill(48'hDEAD_BEEF_0009);
        LZ  = fill(48'hBAD0_BAD0_BAD0);
        LW0 = fill(48'h1234_5678_9ABC);
        LG  = {48'hC4, 48'hC3, 48'hC2, 48'hC1, 48'hC0};

        repeat (3) step();
        chk("reset_ready", LINEW'(load_ready), LINEW'(1));
        chk("reset_hold", LINEW'(core_hold), LINEW'(0));
        chk("reset_lines", LINEW'(lines_written), LINEW'(0));
        chk("reset_err", LINEW'(bank_err), LINEW'(0));
        chk("reset_rd0", rd_data[0 +: LINEW], '0);
        rst_n = 1'b1;
        step();

        // Line to bank 0 addr 5
        rd_addr[0 +: AW] = 8'd5;
        send_line(0, 1, 5, L1, LN, -1, 0, 0);
        step(); step();
        chk("t1_readback", rd_data[0 +: LINEW], {48'h5, 48'h4, 48'h3, 48'h2, 48'h1});
        chk("t1_lines", LINEW'(lines_written), LINEW'(1));

        // Three back-to-back lines with wrap
        cstart = cyc;
        send_line(2, 1, 8'hFE, L2a, LN, -1, 0, 0);
        send_line(2, 0, 0, L2b, LN, -1, 0, 0);
        send_line(2, 0, 0, L2c, LN, -1, 0, 0);
        step();
        chk("t2_cycles", LINEW'(cyc - cstart), LINEW'(18));
        rd_addr[4*AW +: AW] = 8'hFE;
        rd_addr[5*AW +: AW] = 8'hFF;
        step();
        chk("t2_addr_fe", rd_data[4*LINEW +: LINEW], L2a);
        chk("t2_addr_ff", rd_data[5*LINEW +: LINEW], L2b);
        rd_addr[4*AW +: AW] = 8'h00;
        step();
        chk("t2_addr_00", rd_data[4*LINEW +: LINEW], L2c);

        // Write-first on both bank-3 ports
        rd_addr[6*AW +: AW] = 8'd7;
        rd_addr[7*AW +: AW] = 8'd7;
        send_line(3, 1, 7, L3, LN, -1, 0, 0);
        step();
        chk("t3_wf_p0", rd_data[6*LINEW +: LINEW], L3);
        chk("t3_wf_p1", rd_data[7*LINEW +: LINEW], L3);

        // Out-of-range bank
        rd_addr[0 +: AW] = 8'd5;
        send_line(6, 0, 0, fill(48'hFFFF_0000_FFFF), LN, -1, 0, 0);
        step();
        chk("t4_bank_err", LINEW'(bank_err), LINEW'(1));
        chk("t4_lines", LINEW'(lines_written), LINEW'(5));
        chk("t4_bank0_kept", rd_data[0 +: LINEW], L1);

        // Reset mid-line
        send_line(1, 1, 9, LX, LN, -1, 0, 0);
        step();
        send_line(1, 1, 9, LZ, 3, -1, 0, 0);
        rst_n = 1'b0;
        step();
        chk("t5_rst_ready", LINEW'(load_ready), LINEW'(1));
        chk("t5_rst_lines", LINEW'(lines_written), LINEW'(0));
        chk("t5_rst_err", LINEW'(bank_err), LINEW'(0));
        chk("t5_rst_rd", rd_data[2*LINEW +: LINEW], '0);
        rst_n = 1'b1;
        step();
        rd_addr[2*AW +: AW] = 8'd9;
        rd_addr[3*AW +: AW] = 8'd0;
        send_line(1, 0, 0, LW0, LN, -1, 0, 0);
        step(); step();
        chk("t5_addr9_kept", rd_data[2*LINEW +: LINEW], LX);
        chk("t5_addr0_new", rd_data[3*LINEW +: LINEW], LW0);

        // Valid gap between lanes 1 and 2
        rd_addr[8*AW +: AW] = 8'd3;
        send_line(4, 1, 3, LG, LN, 2, 4, 0);
        step(); step();
        chk("t6_gap_line", rd_data[8*LINEW +: LINEW], {48'hC4, 48'hC3, 48'hC2, 48'hC1, 48'hC0});

        // Randomized traffic
        rnd_rd = 1'b1;
        for (int n = 0; n < 60; n++) begin
            for (int k = 0; k < LN; k++) LR[k*LW +: LW] = LW'({$urandom, $urandom});
            send_line($urandom_range(0, 7), ($urandom % 3) == 0, int'(pick_addr()), LR, LN,
                      ($urandom % 4 == 0) ? int'($urandom_range(1, LN - 1)) : -1,
                      $urandom_range(1, 3), 1);
            repeat ($urandom_range(0, 2)) step();
        end
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
